axi_lite_txn_scheduler: RTL and testbench
=========================================

// Module: axi_lite_txn_scheduler
// PURPOSE: Shares one AXI4-Lite slave among NUM_REQ simple requesters via a round-robin arbiter.
//   Captures the granted request, drives the AXI4-Lite AW/W/B or AR/R handshake to the slave,
//   returns read data/response and a one-cycle done pulse. Strictly one outstanding transaction.
// PARAMETERS
//   NUM_REQ     2   number of requesters (>=2)
//   ADDR_WIDTH  32  AXI address width
//   DATA_WIDTH  32  AXI data width
// PORTS
//   PCLK       in   1                   clock, all logic rising-edge
//   PRESETn    in   1                   reset, asynchronous, active-low
//   req        in   NUM_REQ             request per requester, held until its done pulse
//   req_we     in   NUM_REQ             1=write, 0=read, per requester
//   req_addr   in   NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata  in   NUM_REQ*DATA_WIDTH  packed write data, same packing
//   done       out  NUM_REQ             one-hot, one-cycle completion pulse
//   rsp_rdata  out  DATA_WIDTH          read data of completed read (0 after writes), valid with done
//   rsp_resp   out  2                   BRESP/RRESP of completed transaction, valid with done
//   AWADDR     out  ADDR_WIDTH          write address to slave
//   AWVALID    out  1                   write address valid
//   AWREADY    in   1                   write address ready
//   WDATA      out  DATA_WIDTH          write data
//   WVALID     out  1                   write data valid
//   WREADY     in   1                   write data ready
//   BRESP      in   2                   write response
//   BVALID     in   1                   write response valid
//   BREADY     out  1                   write response ready
//   ARADDR     out  ADDR_WIDTH          read address
//   ARVALID    out  1                   read address valid
//   ARREADY    in   1                   read address ready
//   RDATA      in   DATA_WIDTH          read data
//   RRESP      in   2                   read response
//   RVALID     in   1                   read data valid
//   RREADY     out  1                   read data ready
// BEHAVIOUR
// - Reset (async): state IDLE, all VALID/READY outputs 0, done 0, rsp_* 0, addr/data outputs 0, rr pointer -> requester 0 highest.
// - FSM IDLE->ADDR->RESP->DONE->IDLE. IDLE: if any req, grant first set bit at/after pointer (wrapping);
//   latch addr/wdata/we of grantee, pointer <= grantee+1 mod NUM_REQ. No req: stay IDLE.
// - ADDR write: AWVALID,WVALID rise in the cycle after grant; each drops the cycle after its own handshake
//   (AW and W independent, either order or same cycle). Both done -> RESP. Read: ARVALID until ARREADY -> RESP.
// - VALIDs never drop before handshake; AWADDR/WDATA/ARADDR stable while VALID high.
// - RESP: BREADY (write) or RREADY (read) =1; on BVALID/RVALID handshake capture resp (+RDATA) -> DONE.
// - DONE: done[grantee]=1 for exactly that cycle, rsp_* valid; requester drops req in this cycle. Next cycle IDLE.
// - Minimum write/read latency with zero-wait slave: req seen in IDLE at t -> done at t+3.
// - req deassertion mid-transaction is ignored; transaction completes, done still pulses.
// - Slave error (2'b10/2'b11) passed through unchanged on rsp_resp; no retry.
// - rsp_rdata/rsp_resp hold last value outside DONE. Unexpected B/R VALID outside RESP: READY low, ignored.
// STRUCTURE
// - axi_ctrl_pkg: state enum {IDLE,ADDR,RESP,DONE}, resp constants OKAY=2'b00, EXOKAY, SLVERR=2'b10, DECERR.
// - Sub-module rr_arbiter (NUM_REQ): req + pointer -> one-hot grant; instantiated once.
// TESTING
// - Single write, req[0], addr 0x10, data 0xA5A5_0001, zero-wait slave -> AW/W same cycle, done[0] at t+3, resp 00.
// - req[0],req[1] reads held together -> grants 0,1,0,1 alternate; no requester granted twice in a row.
// - AWREADY 3 cycles after WREADY -> WVALID drops first, AWVALID held with stable AWADDR, single B accepted.
// - Read of 0x24 returning RDATA 0xDEAD_BEEF, RRESP 10 -> rsp_rdata 0xDEADBEEF, rsp_resp 10 with done pulse.
// - PRESETn low during RESP -> all VALID/READY 0 immediately, FSM IDLE, next grant goes to requester 0.
// - req dropped during ADDR -> transaction still completes, done pulses once, no second transaction issued.

Source files
------------

// File: rtl/axi_lite_txn_scheduler_pkg.sv
// Shared types for the AXI4-Lite transaction scheduler: FSM states and AXI response codes.
package axi_lite_txn_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StResp,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } axi_resp_e;

endpackage

// File: rtl/axi_lite_txn_scheduler_if.sv
// AXI4-Lite bus between the scheduler (master) and the shared slave.
interface axi_lite_txn_scheduler_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axi_lite_txn_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr (wrapping) wins.
module axi_lite_txn_scheduler_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       gnt_valid
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [IdxW-1:0] idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IdxW'((32'(ptr) + k) % NUM_REQ);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
        gnt[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_lite_txn_scheduler.sv
// Shares one AXI4-Lite slave among NUM_REQ requesters; one transaction in flight at a time.
module axi_lite_txn_scheduler
  import axi_lite_txn_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             done,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic [1:0]                     rsp_resp,
  axi_lite_txn_scheduler_if.master       axi
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  state_e                state_q, state_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  aw_pend_q, aw_pend_d;
  logic                  w_pend_q, w_pend_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  axi_resp_e             resp_q, resp_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IdxW-1:0]       arb_idx;
  logic                  arb_valid;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  axi_lite_txn_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  // One-hot select of the winning requester's fields.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    axi.AWVALID = 1'b0;
    axi.WVALID  = 1'b0;
    axi.ARVALID = 1'b0;
    axi.BREADY  = 1'b0;
    axi.RREADY  = 1'b0;
    done        = '0;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          gnt_d     = arb_gnt;
          ptr_d     = (32'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + IdxW'(1);
          we_d      = sel_we;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          aw_pend_d = sel_we;
          w_pend_d  = sel_we;
          state_d   = StAddr;
        end
      end

      StAddr: begin
        if (we_q) begin
          // AW and W channels complete independently, in any order.
          axi.AWVALID = aw_pend_q;
          axi.WVALID  = w_pend_q;
          if (axi.AWREADY) aw_pend_d = 1'b0;
          if (axi.WREADY)  w_pend_d  = 1'b0;
          if (!aw_pend_d && !w_pend_d) state_d = StResp;
        end else begin
          axi.ARVALID = 1'b1;
          if (axi.ARREADY) state_d = StResp;
        end
      end

      StResp: begin
        if (we_q) begin
          axi.BREADY = 1'b1;
          if (axi.BVALID) begin
            resp_d  = axi_resp_e'(axi.BRESP);
            rdata_d = '0;
            state_d = StDone;
          end
        end else begin
          axi.RREADY = 1'b1;
          if (axi.RVALID) begin
            resp_d  = axi_resp_e'(axi.RRESP);
            rdata_d = axi.RDATA;
            state_d = StDone;
          end
        end
      end

      StDone: begin
        done    = gnt_q;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      gnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RespOkay;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  // Addresses and data come straight from the grant-time latch, so they are stable under VALID.
  assign axi.AWADDR = addr_q;
  assign axi.ARADDR = addr_q;
  assign axi.WDATA  = wdata_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_resp   = resp_q;

endmodule

// File: tb/tb_axi_lite_txn_scheduler.sv
// Randomized and directed bench for axi_lite_txn_scheduler with a transaction-level reference model.
module tb_axi_lite_txn_scheduler;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            PCLK = 1'b0;
  logic            PRESETn = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    done;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;

  axi_lite_txn_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi_lite_txn_scheduler #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .done      (done),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .axi       (axi)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  // Environment knobs
  int unsigned rdy_pct = 100, b_dly = 0, r_dly = 0, req_pct = 0, wr_pct = 50;
  bit          slave_manual = 0, auto_req = 0, force_b = 0, force_r = 0;
  logic [1:0]  force_bresp = 2'b00, force_rresp = 2'b00;
  logic [31:0] force_rdata = '0;

  // Slave state
  bit s_aw_got, s_w_got, s_ar_got, s_b_drop, s_r_drop;
  int s_b_cnt, s_r_cnt, aw_hs_cnt, b_hs_cnt;

  // Reference model: the transaction the scheduler must be carrying out
  bit          m_busy, m_done, m_aw, m_w, m_ar, m_resp, m_we;
  int          m_g, m_ptr;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [1:0]  m_rsp;

  int done_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_aw = 0; m_w = 0; m_ar = 0; m_resp = 0; m_we = 0;
    m_g = 0; m_ptr = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_rsp = 2'b00;
  endtask

  task automatic slave_reset();
    s_aw_got = 0; s_w_got = 0; s_ar_got = 0; s_b_drop = 0; s_r_drop = 0;
    s_b_cnt = 0; s_r_cnt = 0;
    axi.AWREADY = 0; axi.WREADY = 0; axi.ARREADY = 0;
    axi.BVALID = 0; axi.BRESP = 2'b00; axi.RVALID = 0; axi.RDATA = '0; axi.RRESP = 2'b00;
  endtask

  task automatic check_outputs();
    logic [N-1:0] ed;
    ed = '0;
    if (m_done) ed[m_g] = 1'b1;
    chk("done", 64'(done), 64'(ed));
    chk("awvalid", 64'(axi.AWVALID), 64'(m_aw));
    chk("wvalid", 64'(axi.WVALID), 64'(m_w));
    chk("arvalid", 64'(axi.ARVALID), 64'(m_ar));
    chk("bready", 64'(axi.BREADY), 64'(m_resp && m_we));
    chk("rready", 64'(axi.RREADY), 64'(m_resp && !m_we));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
    chk("rsp_resp", 64'(rsp_resp), 64'(m_rsp));
    if (m_aw) chk("awaddr", 64'(axi.AWADDR), 64'(m_addr));
    if (m_w)  chk("wdata", 64'(axi.WDATA), 64'(m_wdata));
    if (m_ar) chk("araddr", 64'(axi.ARADDR), 64'(m_addr));
    for (int i = 0; i < N; i++) if (done[i]) done_log.push_back(i);
  endtask

  task automatic drive_requesters();
    for (int i = 0; i < N; i++) begin
      if (done[i]) req[i] = 1'b0;
      else if (auto_req && !req[i] && $urandom_range(99) < req_pct) begin
        req[i]                = 1'b1;
        req_we[i]             = ($urandom_range(99) < wr_pct);
        req_addr[i*AW +: AW]  = $urandom & 32'hFFFF_FFFC;
        req_wdata[i*DW +: DW] = $urandom;
      end
    end
  endtask

  task automatic drive_slave();
    if (!slave_manual) begin
      axi.AWREADY = ($urandom_range(99) < rdy_pct);
      axi.WREADY  = ($urandom_range(99) < rdy_pct);
      axi.ARREADY = ($urandom_range(99) < rdy_pct);
    end
    if (s_b_drop) begin axi.BVALID = 0; s_b_drop = 0; end
    if (s_r_drop) begin axi.RVALID = 0; s_r_drop = 0; end
    if (s_aw_got && s_w_got && !axi.BVALID) begin
      if (s_b_cnt == 0) begin
        axi.BVALID = 1;
        axi.BRESP  = force_b ? force_bresp : 2'($urandom_range(3));
        s_aw_got = 0; s_w_got = 0;
      end else s_b_cnt--;
    end
    if (s_ar_got && !axi.RVALID) begin
      if (s_r_cnt == 0) begin
        axi.RVALID = 1;
        axi.RDATA  = force_r ? force_rdata : $urandom;
        axi.RRESP  = force_r ? force_rresp : 2'($urandom_range(3));
        s_ar_got = 0;
      end else s_r_cnt--;
    end
  endtask

  task automatic slave_observe();
    bit both_before;
    both_before = s_aw_got && s_w_got;
    if (axi.AWVALID && axi.AWREADY) begin s_aw_got = 1; aw_hs_cnt++; end
    if (axi.WVALID && axi.WREADY) s_w_got = 1;
    if (!both_before && s_aw_got && s_w_got) s_b_cnt = int'($urandom_range(b_dly));
    if (axi.ARVALID && axi.ARREADY) begin s_ar_got = 1; s_r_cnt = int'($urandom_range(r_dly)); end
    if (axi.BVALID && axi.BREADY) begin s_b_drop = 1; b_hs_cnt++; end
    if (axi.RVALID && axi.RREADY) s_r_drop = 1;
  endtask

  // Advance the model across the coming rising edge using the inputs as driven this cycle.
  task automatic model_step();
    bit found;
    if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req[(m_ptr + k) % N]) begin
          found   = 1;
          m_g     = (m_ptr + k) % N;
        end
      end
      if (found) begin
        m_busy  = 1;
        m_ptr   = (m_g + 1) % N;
        m_we    = req_we[m_g];
        m_addr  = req_addr[m_g*AW +: AW];
        m_wdata = req_wdata[m_g*DW +: DW];
        m_aw    = m_we;
        m_w     = m_we;
        m_ar    = !m_we;
      end
    end else if (m_aw || m_w || m_ar) begin
      if (m_aw && axi.AWREADY) m_aw = 0;
      if (m_w && axi.WREADY)   m_w  = 0;
      if (m_ar && axi.ARREADY) m_ar = 0;
      if (!(m_aw || m_w || m_ar)) m_resp = 1;
    end else if (m_resp) begin
      if (m_we ? axi.BVALID : axi.RVALID) begin
        m_resp  = 0;
        m_done  = 1;
        m_rsp   = m_we ? axi.BRESP : axi.RRESP;
        m_rdata = m_we ? 32'h0 : axi.RDATA;
      end
    end
  endtask

  task automatic begin_cycle();
    @(negedge PCLK);
    check_outputs();
    drive_requesters();
    drive_slave();
  endtask

  task automatic end_cycle();
    #1;
    slave_observe();
    model_step();
  endtask

  task automatic apply_reset();
    PRESETn = 1'b0;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    slave_reset();
    model_reset();
    #1;
    chk("rst_valid_ready",
        64'({axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY, axi.RREADY}), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_rsp", 64'({rsp_resp, rsp_rdata}), 64'h0);
    chk("rst_addr", 64'({axi.AWADDR, axi.ARADDR}), 64'h0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  task automatic wait_done(input string nm, input int max, input logic [N-1:0] exp);
    logic [N-1:0] seen;
    seen = '0;
    for (int k = 0; k < max; k++) begin
      begin_cycle();
      seen = done;
      end_cycle();
      if (seen != '0) break;
    end
    chk(nm, 64'(seen), 64'(exp));
  endtask

  task automatic drain();
    auto_req = 0;
    for (int k = 0; k < 80; k++) begin
      begin_cycle();
      end_cycle();
      if (!m_busy && req == '0) break;
    end
    chk("drain_idle", 64'(req), 64'h0);
  endtask

  initial begin
    int b0, a0, cnt;
    slave_reset();
    model_reset();
    apply_reset();

    // Single write, zero-wait slave: done three cycles after the request is seen.
    force_b = 1; force_bresp = 2'b00;
    begin_cycle();
    req[0] = 1; req_we[0] = 1; req_addr[0 +: AW] = 32'h10; req_wdata[0 +: DW] = 32'hA5A5_0001;
    end_cycle();
    begin_cycle();
    chk("t1_aw_w_same_cycle", 64'({axi.AWVALID, axi.WVALID}), 64'h3);
    chk("t1_awaddr", 64'(axi.AWADDR), 64'h10);
    chk("t1_wdata", 64'(axi.WDATA), 64'hA5A5_0001);
    end_cycle();
    begin_cycle();
    chk("t1_bready", 64'(axi.BREADY), 64'h1);
    end_cycle();
    begin_cycle();
    chk("t1_done_t3", 64'(done), 64'h1);
    chk("t1_resp", 64'(rsp_resp), 64'h0);
    end_cycle();
    drain();

    // Two readers held together alternate.
    apply_reset();
    done_log.delete();
    auto_req = 1; req_pct = 100; wr_pct = 0;
    for (int k = 0; k < 60 && done_log.size() < 4; k++) begin begin_cycle(); end_cycle(); end
    drain();
    chk("t2_count", 64'(done_log.size() >= 4), 64'h1);
    for (int k = 0; k < done_log.size() && k < 4; k++)
      chk("t2_grant_order", 64'(done_log[k]), 64'(k % 2));
    for (int k = 1; k < done_log.size(); k++)
      chk("t2_no_repeat", 64'(done_log[k] != done_log[k-1]), 64'h1);
    wr_pct = 50;

    // AWREADY three cycles after WREADY.
    apply_reset();
    slave_manual = 1;
    b0 = b_hs_cnt;
    begin_cycle();
    req[0] = 1; req_we[0] = 1; req_addr[0 +: AW] = 32'h40; req_wdata[0 +: DW] = 32'h1234_5678;
    end_cycle();
    begin_cycle(); axi.WREADY = 1; end_cycle();
    begin_cycle(); axi.WREADY = 0;
    chk("t3_wvalid_dropped", 64'(axi.WVALID), 64'h0);
    chk("t3_awvalid_held", 64'(axi.AWVALID), 64'h1);
    chk("t3_awaddr_stable", 64'(axi.AWADDR), 64'h40);
    end_cycle();
    begin_cycle(); chk("t3_awaddr_stable2", 64'(axi.AWADDR), 64'h40); end_cycle();
    begin_cycle(); axi.AWREADY = 1; end_cycle();
    begin_cycle(); axi.AWREADY = 0;
    chk("t3_aw_dropped_bready", 64'({axi.AWVALID, axi.BREADY}), 64'h1);
    end_cycle();
    wait_done("t3_done", 10, 2'b01);
    chk("t3_single_b", 64'(b_hs_cnt - b0), 64'h1);
    slave_manual = 0;
    drain();

    // Read with slave error.
    apply_reset();
    force_r = 1; force_rdata = 32'hDEAD_BEEF; force_rresp = 2'b10;
    begin_cycle();
    req[0] = 1; req_we[0] = 0; req_addr[0 +: AW] = 32'h24;
    end_cycle();
    begin_cycle(); chk("t4_araddr", 64'(axi.ARADDR), 64'h24); end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle();
    chk("t4_done", 64'(done), 64'h1);
    chk("t4_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    chk("t4_rresp", 64'(rsp_resp), 64'h2);
    end_cycle();
    begin_cycle(); chk("t4_rdata_hold", 64'(rsp_rdata), 64'hDEAD_BEEF); end_cycle();
    force_r = 0;
    drain();

    // Reset while waiting for R; pointer must return to requester 0.
    apply_reset();
    r_dly = 6;
    begin_cycle(); req[0] = 1; req_we[0] = 0; req_addr[0 +: AW] = 32'h8; end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle(); chk("t5_in_resp", 64'(axi.RREADY), 64'h1);
    apply_reset();
    r_dly = 0;
    begin_cycle();
    req = 2'b11; req_we = 2'b00; req_addr = {32'h104, 32'h100};
    end_cycle();
    wait_done("t5_first_grant_req0", 12, 2'b01);
    drain();

    // Request withdrawn during the address phase.
    apply_reset();
    slave_manual = 1;
    a0 = aw_hs_cnt;
    begin_cycle();
    req[0] = 1; req_we[0] = 1; req_addr[0 +: AW] = 32'h80; req_wdata[0 +: DW] = 32'h5555_AAAA;
    end_cycle();
    begin_cycle(); req[0] = 0; chk("t6_awvalid", 64'(axi.AWVALID), 64'h1); end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle(); axi.AWREADY = 1; axi.WREADY = 1; end_cycle();
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      begin_cycle();
      axi.AWREADY = 0; axi.WREADY = 0;
      if (done[0]) cnt++;
      end_cycle();
    end
    chk("t6_single_done", 64'(cnt), 64'h1);
    chk("t6_single_aw", 64'(aw_hs_cnt - a0), 64'h1);
    slave_manual = 0; force_b = 0;

    // Random traffic.
    apply_reset();
    rdy_pct = 60; b_dly = 3; r_dly = 3; req_pct = 30; wr_pct = 50; auto_req = 1;
    for (int k = 0; k < 3000; k++) begin begin_cycle(); end_cycle(); end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
